enc_rr_arbiter_4: RTL and testbench
===================================

Name: enc_rr_arbiter_4

Overview:
Sequential round-robin arbiter that shares one downstream resource among 4 requesters. It wraps the 4-to-2 encoding function (one-hot grant to 2-bit index, with enable-in and an "enabled but nothing requested" enable-out) in a grant/hold/release state machine. It sits between requesting blocks and the shared datapath and drives the datapath's select index.

Parameters:
HOLD_MAX, 8, max consecutive cycles one grant may be held before forced release; 0 = no limit.
CNT_W, 4, width of hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
EIN  in  1  global enable; when low, no new grants are issued and any held grant is released.
req  in  4  request vector, one bit per requester, level-sensitive.
done  in  1  current grantee signals completion; sampled only in GRANT.
gnt  out  4  one-hot grant, registered.
out  out  2  encoded index of granted requester, registered; valid only when gnt_valid=1.
gnt_valid  out  1  high while a grant is held, registered.
EOUT  out  1  registered; 1 when EIN=1 and req=4'b0000 on previous edge (enabled, nothing asserted).
timeout  out  1  one-cycle pulse on forced release due to HOLD_MAX.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; gnt=0, out=0, gnt_valid=0, EOUT=0, timeout=0, hold count=0, last pointer=3, so requester 0 has top priority first.
- States: IDLE, GRANT, GAP.
- IDLE: if EIN=1 and req!=0, select the first set bit searching last+1, last+2, … mod 4. At the next edge: gnt=onehot(sel), out=sel, gnt_valid=1, hold count=1, state goes to GRANT. Latency is 1 cycle from req sampled to grant visible. Otherwise remain in IDLE with gnt=0.
- GRANT: release at the edge if any of these is true:
  - done=1
  - req[out]=0
  - EIN=0
  - HOLD_MAX!=0 and hold count==HOLD_MAX
- On release: gnt=0, gnt_valid=0, last=out, state goes to GAP. out keeps its last value.
- timeout=1 for exactly the release cycle only when the HOLD_MAX condition caused the release and done=0 and req[out]=1. If done and timeout coincide, done wins and timeout=0.
- While GRANT is not released: hold count increments, saturating at 2^CNT_W-1.
- GAP: one dead cycle with no grant. Next edge goes to IDLE; no arbitration occurs in GAP. Minimum turnaround between grants is 2 cycles.
- Requests arriving or dropping for non-granted requesters during GRANT are ignored until arbitration in IDLE.
- A requester that keeps req high after release still loses to any other pending requester, because last moved to it.
- Only one requester pending: it is re-granted after GAP+IDLE.
- EOUT is updated every edge from EIN & ~|req, independent of state. EOUT=0 whenever EIN=0.
- Input X on req while EIN=0 must not propagate X to gnt, out or gnt_valid.
- rst mid-GRANT: all outputs return to reset values at that edge; the pointer returns to 3.

Test Plan:
1. Reset, then EIN=1, req=4'b0000 for 3 cycles → gnt=0, gnt_valid=0, EOUT=1 from the 2nd edge onward.
2. req=4'b1111 held, done pulsed 1 cycle after each grant → grants rotate 0,1,2,3,0 with out=0,1,2,3,0; gnt=0001,0010,0100,1000,0001; a 2-cycle gap between grants.
3. req=4'b0100 held, done=0, HOLD_MAX=8 → gnt=0100 for exactly 8 cycles, timeout=1 on the release cycle, then re-granted after GAP+IDLE.
4. Grant held on requester 1, EIN dropped to 0 (req=4'bXXXX) → next edge gnt=0, gnt_valid=0, EOUT=0, no X on outputs; no regrant while EIN=0.
5. Grant on requester 2, rst=1 for 1 cycle with req=4'b1111 still asserted → outputs zero at that edge; after rst drops, first grant goes to requester 0 (out=0).
6. Requester 3 drops req mid-grant, others idle → release the next edge, timeout=0, last=3; a new req=4'b1001 then grants requester 0.

Source files
------------

// File: rtl/enc_rr_arbiter_4.sv
// enc_rr_arbiter_4: four-requester round-robin arbiter driving a shared
// datapath select. A one-hot grant is encoded to a 2-bit index and held
// until done, request drop, enable drop or the hold limit. Each release
// is followed by a one-cycle gap with no grant.
module enc_rr_arbiter_4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EIN,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] out,
  output logic       gnt_valid,
  output logic       EOUT,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [1:0]       last_r;

  logic [1:0]       pick_s;
  logic             hold_hit_s;
  logic             release_s;
  logic             tmo_s;

  // Round-robin search: first set request at last+1, last+2, ... (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Index to one-hot grant.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // One-hot grant back to its 2-bit index (4-to-2 encoder).
  function automatic logic [1:0] enc4to2(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign pick_s = rr_pick(req, last_r);

  // Release decision for the held grant; enable drop is checked first so an
  // unknown request vector while disabled never reaches the outputs.
  always_comb begin
    hold_hit_s = 1'b0;
    release_s  = 1'b0;
    tmo_s      = 1'b0;
    if (HOLD_MAX != 0) begin
      hold_hit_s = (hold_cnt_r == HOLD_LIM);
    end else begin
      hold_hit_s = 1'b0;
    end
    if (!EIN) begin
      release_s = 1'b1;
      tmo_s     = 1'b0;
    end else if (done) begin
      release_s = 1'b1;
      tmo_s     = 1'b0;
    end else if (!req[out]) begin
      release_s = 1'b1;
      tmo_s     = 1'b0;
    end else if (hold_hit_s) begin
      release_s = 1'b1;
      tmo_s     = 1'b1;
    end else begin
      release_s = 1'b0;
      tmo_s     = 1'b0;
    end
  end

  // Grant/hold/gap state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      gnt        <= 4'b0000;
      out        <= 2'd0;
      gnt_valid  <= 1'b0;
      EOUT       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt_r <= {CNT_W{1'b0}};
      last_r     <= 2'd3;
    end else begin
      EOUT    <= EIN & ~(|req);
      timeout <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (EIN && (req != 4'b0000)) begin
            gnt        <= onehot4(pick_s);
            out        <= enc4to2(onehot4(pick_s));
            gnt_valid  <= 1'b1;
            hold_cnt_r <= CNT_ONE;
            state_r    <= S_GRANT;
          end else begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_s) begin
            gnt        <= 4'b0000;
            gnt_valid  <= 1'b0;
            last_r     <= out;
            timeout    <= tmo_s;
            hold_cnt_r <= {CNT_W{1'b0}};
            state_r    <= S_GAP;
          end else if (hold_cnt_r != CNT_SAT) begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        S_GAP: begin
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_rr_arbiter_4.sv
// Directed bench for enc_rr_arbiter_4: each step pushes its expected outputs
// onto a scoreboard queue, applies the inputs for one edge, then pops and
// compares after the edge.
module tb_enc_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic       EIN;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] out;
  logic       gnt_valid;
  logic       EOUT;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] out;
    logic       v;
    logic       eout;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  enc_rr_arbiter_4 #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .EIN(EIN), .req(req), .done(done),
    .gnt(gnt), .out(out), .gnt_valid(gnt_valid), .EOUT(EOUT), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic d,
                      input logic [3:0] eg, input logic [1:0] eo, input logic ev,
                      input logic ee, input logic et);
    exp_t x;
    exp_t y;
    @(negedge clk);
    rst  = r;
    EIN  = e;
    req  = rq;
    done = d;
    x.gnt = eg; x.out = eo; x.v = ev; x.eout = ee; x.tmo = et;
    sb.push_back(x);
    @(posedge clk);
    #1;
    step_no++;
    y = sb.pop_front();
    chk("gnt",       gnt,                 y.gnt);
    chk("out",       {2'b00, out},        {2'b00, y.out});
    chk("gnt_valid", {3'b000, gnt_valid}, {3'b000, y.v});
    chk("EOUT",      {3'b000, EOUT},      {3'b000, y.eout});
    chk("timeout",   {3'b000, timeout},   {3'b000, y.tmo});
  endtask

  initial begin
    logic [1:0] k2;
    rst = 1'b1; EIN = 1'b0; req = 4'b0000; done = 1'b0;

    // 1: reset, then enabled with no requests
    step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

    // 2: all requesting, done one cycle after each grant -> rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      k2 = k[1:0];
      step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0001 << k2, k2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, k2, 1'b0, 1'b0, 1'b0);
      if (k < 4)
        step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, k2, 1'b0, 1'b0, 1'b0);
    end

    // 3: lone requester 2 held to the hold limit -> 8 grant cycles then timeout
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);

    // 4: move grant to requester 1, then disable with unknown requests
    step(1'b0, 1'b1, 4'b0010, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'bxxxx, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

    // 5: grant requester 2, reset mid-grant, then requester 0 wins first
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // 6: grant requester 3, drop its request mid-grant, then 1001 -> requester 0
    step(1'b0, 1'b1, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // done coinciding with the hold limit releases without timeout
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
